// File: rtl/lda_pkg.sv
// rtl/lda_pkg.sv - shared types and constants for the LDA line scheduler
package lda_pkg;

    localparam int X_W          = 9;
    localparam int Y_W          = 8;
    localparam int COLOUR_W_MAX = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } lda_state_t;

    // Colour is stored at its widest supported size; the scheduler uses the low CW bits.
    typedef struct packed {
        logic [X_W-1:0]          x0;
        logic [Y_W-1:0]          y0;
        logic [X_W-1:0]          x1;
        logic [Y_W-1:0]          y1;
        logic [COLOUR_W_MAX-1:0] colour;
    } line_cmd_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin select starting after the last grant
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_idx,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          grant_valid
);

    logic [IW-1:0] cidx;

    // Scan last_idx+1 .. last_idx+N so the previous winner is considered last.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        cidx        = '0;
        for (int i = 1; i <= N; i++) begin
            cidx = IW'((int'(last_idx) + i) % N);
            if (!grant_valid && req[cidx]) begin
                grant_valid = 1'b1;
                grant[cidx] = 1'b1;
                grant_idx   = cidx;
            end
        end
    end

endmodule

// File: rtl/lda_line_scheduler.sv
// rtl/lda_line_scheduler.sv - shares one line-drawing datapath among NUM_REQ requesters
module lda_line_scheduler
    import lda_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 200000,
    parameter int CW             = 3,
    localparam int OW            = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                    csi_clockreset_clk,
    input  logic                    csi_clockreset_reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [X_W*NUM_REQ-1:0]  req_x0,
    input  logic [Y_W*NUM_REQ-1:0]  req_y0,
    input  logic [X_W*NUM_REQ-1:0]  req_x1,
    input  logic [Y_W*NUM_REQ-1:0]  req_y1,
    input  logic [CW*NUM_REQ-1:0]   req_colour,
    output logic [X_W-1:0]          lda_x0,
    output logic [X_W-1:0]          lda_x1,
    output logic [Y_W-1:0]          lda_y0,
    output logic [Y_W-1:0]          lda_y1,
    output logic                    lda_go,
    input  logic                    lda_done,
    input  logic                    lda_plot,
    output logic                    vga_plot,
    output logic [CW-1:0]           vga_colour,
    output logic                    busy,
    output logic [OW-1:0]           cur_owner,
    output logic                    timeout_err,
    input  logic                    err_clear
);

    localparam int              WD_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    lda_state_t         state;
    logic [WD_W-1:0]    wd_cnt;
    line_cmd_t          cmd_q;
    line_cmd_t          cmd_sel;
    logic [NUM_REQ-1:0] grant;
    logic [OW-1:0]      grant_idx;
    logic               grant_valid;
    logic               unused_colour_bits;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (OW)
    ) u_rr_arbiter (
        .req         (req_valid),
        .last_idx    (cur_owner),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    always_comb begin
        cmd_sel        = '0;
        cmd_sel.x0     = req_x0[grant_idx*X_W +: X_W];
        cmd_sel.y0     = req_y0[grant_idx*Y_W +: Y_W];
        cmd_sel.x1     = req_x1[grant_idx*X_W +: X_W];
        cmd_sel.y1     = req_y1[grant_idx*Y_W +: Y_W];
        cmd_sel.colour = COLOUR_W_MAX'(req_colour[grant_idx*CW +: CW]);
    end

    always_ff @(posedge csi_clockreset_clk) begin
        if (csi_clockreset_reset) begin
            state       <= IDLE;
            cmd_q       <= '0;
            lda_go      <= 1'b0;
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
            cur_owner   <= OW'(NUM_REQ - 1);
        end else begin
            // A watchdog abort below overrides this clear in the same cycle.
            if (err_clear) begin
                timeout_err <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        cmd_q     <= cmd_sel;
                        cur_owner <= grant_idx;
                        wd_cnt    <= '0;
                        lda_go    <= 1'b1;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (wd_cnt != WD_LAST) begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                    if (lda_done) begin
                        lda_go <= 1'b0;
                        state  <= DRAIN;
                    end else if (wd_cnt == WD_LAST) begin
                        lda_go      <= 1'b0;
                        timeout_err <= 1'b1;
                        state       <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!lda_done) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    lda_go <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign req_ready  = (state == IDLE) ? grant : '0;
    assign busy       = (state != IDLE);
    assign vga_plot   = lda_plot && (state == RUN);
    assign lda_x0     = cmd_q.x0;
    assign lda_y0     = cmd_q.y0;
    assign lda_x1     = cmd_q.x1;
    assign lda_y1     = cmd_q.y1;
    assign vga_colour = cmd_q.colour[CW-1:0];

    assign unused_colour_bits = ^cmd_q.colour;

endmodule

// File: tb/tb_lda_line_scheduler.sv
// tb/tb_lda_line_scheduler.sv - self-checking bench for lda_line_scheduler
module tb_lda_line_scheduler;

    localparam int NR = 2;
    localparam int T  = 16;
    localparam int CW = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [9*NR-1:0]   req_x0, req_x1;
    logic [8*NR-1:0]   req_y0, req_y1;
    logic [CW*NR-1:0]  req_colour;
    logic [8:0]        lda_x0, lda_x1;
    logic [7:0]        lda_y0, lda_y1;
    logic              lda_go, lda_done, lda_plot, vga_plot, busy, timeout_err, err_clear;
    logic [CW-1:0]     vga_colour;
    logic [0:0]        cur_owner;

    int total = 0;
    int bad   = 0;

    int c_x0[NR], c_y0[NR], c_x1[NR], c_y1[NR], c_col[NR];
    int m_last;
    bit m_err;

    typedef struct {
        logic [NR-1:0] v;
        int w, x0, y0, x1, y1, col, hold, pmode, clr;
        bit keep, nodone;
    } line_vec_t;

    line_vec_t tbl[14];

    always #5 clk = ~clk;

    lda_line_scheduler #(
        .NUM_REQ        (NR),
        .TIMEOUT_CYCLES (T),
        .CW             (CW)
    ) dut (
        .csi_clockreset_clk   (clk),
        .csi_clockreset_reset (rst),
        .req_valid            (req_valid),
        .req_ready            (req_ready),
        .req_x0               (req_x0),
        .req_y0               (req_y0),
        .req_x1               (req_x1),
        .req_y1               (req_y1),
        .req_colour           (req_colour),
        .lda_x0               (lda_x0),
        .lda_x1               (lda_x1),
        .lda_y0               (lda_y0),
        .lda_y1               (lda_y1),
        .lda_go               (lda_go),
        .lda_done             (lda_done),
        .lda_plot             (lda_plot),
        .vga_plot             (vga_plot),
        .vga_colour           (vga_colour),
        .busy                 (busy),
        .cur_owner            (cur_owner),
        .timeout_err          (timeout_err),
        .err_clear            (err_clear)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_cmds();
        for (int r = 0; r < NR; r++) begin
            req_x0[9*r +: 9]       = c_x0[r][8:0];
            req_y0[8*r +: 8]       = c_y0[r][7:0];
            req_x1[9*r +: 9]       = c_x1[r][8:0];
            req_y1[8*r +: 8]       = c_y1[r][7:0];
            req_colour[CW*r +: CW] = c_col[r][CW-1:0];
        end
    endtask

    function automatic int rr_pick(input logic [NR-1:0] v, input int last);
        for (int k = 1; k <= NR; k++) begin
            if (v[(last + k) % NR]) return (last + k) % NR;
        end
        return -1;
    endfunction

    task automatic check_cmd(input string tag, input int w);
        check({tag, "/lda_x0"}, lda_x0, c_x0[w][8:0]);
        check({tag, "/lda_y0"}, lda_y0, c_y0[w][7:0]);
        check({tag, "/lda_x1"}, lda_x1, c_x1[w][8:0]);
        check({tag, "/lda_y1"}, lda_y1, c_y1[w][7:0]);
        check({tag, "/vga_colour"}, vga_colour, c_col[w][CW-1:0]);
    endtask

    // One granted line, timed from the grant cycle (rel 0): LDA plots npix pixels,
    // raises done for hold+1 cycles, or never raises it when the watchdog must fire.
    task automatic run_line(input string tag, input logic [NR-1:0] v, input int w, input int hold,
                            input int pmode, input int clr, input bit keep, input bit nodone);
        int dx, dy, npix, rr, ll;
        bit to, pl, clr_in, exp_err;
        logic [NR-1:0] vv, exp_rdy;
        dx   = c_x1[w] - c_x0[w];
        dy   = c_y1[w] - c_y0[w];
        if (dx < 0) dx = -dx;
        if (dy < 0) dy = -dy;
        npix = ((dx > dy) ? dx : dy) + 1;
        to   = nodone || (npix + 1 > T);
        rr   = to ? T : npix + 1;
        ll   = to ? T + 2 : npix + 3 + hold;
        clr_in = (clr >= 0) && (clr < ll);
        if (to) exp_err = !(clr_in && clr > T);
        else    exp_err = m_err && !clr_in;
        vv = v;
        for (int rel = 0; rel < ll; rel++) begin
            req_valid = vv;
            apply_cmds();
            case (pmode)
                1:       pl = 1'b1;
                2:       pl = 1'($urandom);
                default: pl = (rel >= 1) && (rel <= npix);
            endcase
            lda_plot  = pl;
            lda_done  = !to && (rel >= npix + 1) && (rel <= npix + 1 + hold);
            err_clear = clr_in && (rel == clr);
            #1;
            exp_rdy = (rel == 0) ? (NR'(1) << w) : '0;
            check({tag, "/req_ready"}, req_ready, exp_rdy);
            check({tag, "/vga_plot"}, vga_plot, pl && (rel >= 1) && (rel <= rr));
            check({tag, "/lda_go"}, lda_go, (rel >= 1) && (rel <= rr));
            check({tag, "/busy"}, busy, rel >= 1);
            if (rel >= 1) check({tag, "/cur_owner"}, cur_owner, w);
            if (rel == 1) check_cmd(tag, w);
            tick();
            if (rel == 0 && !keep) vv[w] = 1'b0;
        end
        lda_plot  = 1'b0;
        lda_done  = 1'b0;
        err_clear = 1'b0;
        check({tag, "/end_go"}, lda_go, 0);
        check({tag, "/end_busy"}, busy, 0);
        check({tag, "/timeout_err"}, timeout_err, exp_err);
        check({tag, "/end_owner"}, cur_owner, w);
        check_cmd({tag, "/hold"}, w);
        m_err  = exp_err;
        m_last = w;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            req_valid = '0;
            lda_plot  = 1'($urandom);
            lda_done  = 1'b0;
            #1;
            check("idle/req_ready", req_ready, 0);
            check("idle/vga_plot", vga_plot, 0);
            check("idle/busy", busy, 0);
            tick();
        end
        lda_plot = 1'b0;
    endtask

    task automatic set_random_cmds();
        int d;
        for (int r = 0; r < NR; r++) begin
            c_x0[r] = $urandom_range(20, 480);
            d       = $urandom_range(0, 18);
            c_x1[r] = ($urandom_range(0, 1) == 1) ? c_x0[r] + d : c_x0[r] - d;
            c_y0[r] = $urandom_range(20, 230);
            d       = $urandom_range(0, 18);
            c_y1[r] = ($urandom_range(0, 1) == 1) ? c_y0[r] + d : c_y0[r] - d;
            c_col[r] = $urandom_range(0, 7);
        end
    endtask

    initial begin
        //           v      w  x0   y0   x1   y1   col hold pm  clr  keep nodone
        tbl[0]  = '{2'b01, 0,   0,   0,  10,  10, 3,  0,  0,  -1, 1'b0, 1'b0};
        tbl[1]  = '{2'b11, 1,   5,   5,   8,   6, 1,  0,  0,  -1, 1'b1, 1'b0};
        tbl[2]  = '{2'b11, 0, 300, 100, 290, 104, 2,  1,  0,  -1, 1'b1, 1'b0};
        tbl[3]  = '{2'b11, 1, 511, 255, 508, 250, 7,  0,  0,  -1, 1'b1, 1'b0};
        tbl[4]  = '{2'b11, 0,   1, 200,   1, 195, 4,  0,  0,  -1, 1'b1, 1'b0};
        tbl[5]  = '{2'b11, 1,  20,  30,  25,  30, 5,  2,  1,  -1, 1'b1, 1'b0};
        tbl[6]  = '{2'b11, 0,  60,  70,  62,  71, 6,  5,  0,  -1, 1'b1, 1'b0};
        tbl[7]  = '{2'b01, 0,   0,   0,  14,   3, 1,  0,  0,  -1, 1'b0, 1'b0};
        tbl[8]  = '{2'b11, 1,  40,  40,  42,  42, 2,  0,  0,  -1, 1'b1, 1'b1};
        tbl[9]  = '{2'b11, 0,   3,   4,   5,   6, 3,  0,  0,   2, 1'b1, 1'b0};
        tbl[10] = '{2'b11, 1,   9,   9,   9,  12, 0,  0,  0,  16, 1'b1, 1'b1};
        tbl[11] = '{2'b01, 0, 100, 100, 104, 100, 5,  0,  0,   0, 1'b0, 1'b0};
        tbl[12] = '{2'b10, 1,   0,   0, 100,   2, 6,  0,  0,  -1, 1'b0, 1'b0};
        tbl[13] = '{2'b11, 0,   7,   7,   7,   7, 7,  1,  0,   3, 1'b1, 1'b0};

        rst = 1'b1; req_valid = '0; lda_done = 1'b0; lda_plot = 1'b0; err_clear = 1'b0;
        for (int r = 0; r < NR; r++) begin
            c_x0[r] = 0; c_y0[r] = 0; c_x1[r] = 0; c_y1[r] = 0; c_col[r] = 0;
        end
        apply_cmds();
        tick();
        tick();
        rst = 1'b0;
        check("reset/lda_go", lda_go, 0);
        check("reset/busy", busy, 0);
        check("reset/cur_owner", cur_owner, NR - 1);
        check("reset/timeout_err", timeout_err, 0);
        check("reset/lda_x1", lda_x1, 0);
        check("reset/vga_colour", vga_colour, 0);
        check("reset/req_ready", req_ready, 0);
        m_last = NR - 1;
        m_err  = 1'b0;

        for (int i = 0; i < 14; i++) begin
            for (int r = 0; r < NR; r++) begin
                if (r == tbl[i].w) begin
                    c_x0[r] = tbl[i].x0; c_y0[r] = tbl[i].y0;
                    c_x1[r] = tbl[i].x1; c_y1[r] = tbl[i].y1; c_col[r] = tbl[i].col;
                end else begin
                    c_x0[r] = (tbl[i].x0 + 131) % 512; c_y0[r] = (tbl[i].y0 + 77) % 256;
                    c_x1[r] = (tbl[i].x1 + 131) % 512; c_y1[r] = (tbl[i].y1 + 77) % 256;
                    c_col[r] = (~tbl[i].col) & 7;
                end
            end
            run_line($sformatf("tbl%0d", i), tbl[i].v, tbl[i].w, tbl[i].hold, tbl[i].pmode,
                     tbl[i].clr, tbl[i].keep, tbl[i].nodone);
        end

        // Reset while requester 1 owns the datapath mid-line.
        c_x0[1] = 0; c_y0[1] = 0; c_x1[1] = 12; c_y1[1] = 0; c_col[1] = 5;
        req_valid = 2'b10;
        apply_cmds();
        #1;
        check("rstmid/req_ready", req_ready, 2'b10);
        tick();
        req_valid = '0;
        for (int i = 0; i < 3; i++) begin
            lda_plot = 1'b1;
            #1;
            check("rstmid/lda_go", lda_go, 1);
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        lda_plot = 1'b0;
        check("rstmid/after_go", lda_go, 0);
        check("rstmid/after_busy", busy, 0);
        check("rstmid/after_owner", cur_owner, NR - 1);
        check("rstmid/after_x1", lda_x1, 0);
        m_last = NR - 1;
        m_err  = 1'b0;
        c_x0[0] = 50; c_y0[0] = 60; c_x1[0] = 53; c_y1[0] = 58; c_col[0] = 2;
        run_line("rstmid/regrant", 2'b11, 0, 0, 0, -1, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            logic [NR-1:0] v;
            int clr;
            set_random_cmds();
            v   = NR'($urandom_range(1, (1 << NR) - 1));
            clr = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 20) : -1;
            run_line($sformatf("rnd%0d", i), v, rr_pick(v, m_last), $urandom_range(0, 4), 2,
                     clr, 1'($urandom), 1'b0);
            idle_cycles($urandom_range(0, 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
